// File: rtl/m1_frame_sequencer_if.sv
// Signal bundle between the M1 frame sequencer, its word filler and the
// downstream consumer. The sequencer is the master side; the environment
// (filler, consumer and run control) is the slave side.
interface m1_frame_sequencer_if;
    logic        enable;
    logic        outReady;
    logic [11:0] fillerWord;
    logic        bufGetWord;
    logic [6:0]  bufRdPointer;
    logic [4:0]  cntGrp;
    logic [11:0] outWord;
    logic        outValid;
    logic        outFrameStart;
    logic        overrun;
    logic        busy;

    modport master (
        input  enable, outReady, fillerWord,
        output bufGetWord, bufRdPointer, cntGrp, outWord,
               outValid, outFrameStart, overrun, busy
    );

    modport slave (
        output enable, outReady, fillerWord,
        input  bufGetWord, bufRdPointer, cntGrp, outWord,
               outValid, outFrameStart, overrun, busy
    );
endinterface

// File: rtl/m1_frame_sequencer.sv
// M1 frame sequencer: paces word requests to the filler on a slot tick,
// captures the returned word and presents it downstream with a valid/ready
// handshake, walking pointer 0..PTR_MAX within group 0..GRP_MAX per frame.
module m1_frame_sequencer #(
    parameter int TICK_DIV = 16,
    parameter int PTR_MAX  = 127,
    parameter int GRP_MAX  = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    m1_frame_sequencer_if.master   bus
);
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [6:0] PTR_LAST  = 7'(PTR_MAX);
    localparam logic [4:0] GRP_LAST  = 5'(GRP_MAX);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        STROBE,
        CAPTURE,
        PRESENT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_tick_cnt;
    logic [6:0]  r_ptr;
    logic [4:0]  r_grp;
    logic [11:0] r_word;
    logic        r_valid;
    logic        r_fstart;
    logic        r_overrun;
    logic        w_tick;
    logic        w_hs;
    logic        w_at_start;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_hs       = r_valid && bus.outReady;
    assign w_at_start = (r_ptr == '0) && (r_grp == '0);

    // Next-state selection; stop requests only take effect at a frame boundary
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.enable) w_next = WAIT_TICK;
            WAIT_TICK: begin
                if (!bus.enable && w_at_start) w_next = IDLE;
                else if (w_tick)               w_next = STROBE;
            end
            STROBE:    w_next = CAPTURE;
            CAPTURE:   w_next = PRESENT;
            PRESENT:   if (w_hs) w_next = WAIT_TICK;
            default:   w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Slot tick divider, free-running outside IDLE
    always_ff @(posedge clk) begin
        if (!reset || r_state == IDLE) r_tick_cnt <= '0;
        else if (w_tick)               r_tick_cnt <= '0;
        else                           r_tick_cnt <= r_tick_cnt + 8'd1;
    end

    // Word capture, handshake, pointer/group advance and overrun tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_grp     <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_fstart  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ptr <= '0;
                    r_grp <= '0;
                    if (bus.enable) r_overrun <= 1'b0;
                end
                CAPTURE: begin
                    r_word   <= bus.fillerWord;
                    r_valid  <= 1'b1;
                    r_fstart <= w_at_start;
                end
                PRESENT: begin
                    if (w_hs) begin
                        r_valid  <= 1'b0;
                        r_fstart <= 1'b0;
                        if (r_ptr == PTR_LAST) begin
                            r_ptr <= '0;
                            r_grp <= (r_grp == GRP_LAST) ? '0 : r_grp + 5'd1;
                        end else begin
                            r_ptr <= r_ptr + 7'd1;
                        end
                    end else if (w_tick) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bufGetWord    = (r_state == STROBE);
    assign bus.busy          = (r_state != IDLE);
    assign bus.bufRdPointer  = r_ptr;
    assign bus.cntGrp        = r_grp;
    assign bus.outWord       = r_word;
    assign bus.outValid      = r_valid;
    assign bus.outFrameStart = r_fstart;
    assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_m1_frame_sequencer.sv
// Self-checking bench for m1_frame_sequencer: randomized filler data and
// ready pattern against a slot/latency-level reference model.
module tb_m1_frame_sequencer;
    localparam int TD    = 5;
    localparam int PM    = 15;
    localparam int GM    = 7;
    localparam int WPG   = PM + 1;
    localparam int FRAME = WPG * (GM + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    m1_frame_sequencer_if bus ();

    m1_frame_sequencer #(
        .TICK_DIV (TD),
        .PTR_MAX  (PM),
        .GRP_MAX  (GM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: run flag, cycles since run start, in-flight word with
    // its strobe cycle, word index within the frame, held data, sticky overrun.
    bit          m_run;
    bit          m_fl;
    int          m_k;
    int          m_sk;
    int          m_word;
    logic [11:0] m_data;
    bit          m_over;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        return m_run && ((m_k % TD) == TD - 1);
    endfunction

    function automatic bit m_presenting();
        return m_fl && (m_k >= m_sk + 2);
    endfunction

    // Advance the model across one rising edge using the inputs seen at it
    task automatic model_step();
        bit t;
        if (!reset) begin
            m_run = 0; m_fl = 0; m_k = 0; m_sk = 0;
            m_word = 0; m_data = '0; m_over = 0;
            return;
        end
        if (!m_run) begin
            if (bus.enable) begin
                m_run = 1; m_k = 0; m_over = 0;
            end
            return;
        end
        t = m_tick();
        if (!m_fl) begin
            if (!bus.enable && m_word == 0) begin
                m_run = 0;
                return;
            end else if (t) begin
                m_fl = 1;
                m_sk = m_k + 1;
            end
        end else if (m_k == m_sk + 1) begin
            m_data = bus.fillerWord;
        end else if (m_k >= m_sk + 2) begin
            if (bus.outReady) begin
                m_fl   = 0;
                m_word = (m_word + 1) % FRAME;
            end else if (t) begin
                m_over = 1;
            end
        end
        m_k++;
    endtask

    task automatic compare();
        bit ev;
        ev = m_presenting();
        chk("busy",       bus.busy,          m_run);
        chk("bufGetWord", bus.bufGetWord,    m_fl && (m_k == m_sk));
        chk("outValid",   bus.outValid,      ev);
        chk("outFrameSt", bus.outFrameStart, ev && (m_word == 0));
        chk("ptr",        bus.bufRdPointer,  m_word % WPG);
        chk("grp",        bus.cntGrp,        m_word / WPG);
        chk("outWord",    bus.outWord,       m_data);
        chk("overrun",    bus.overrun,       m_over);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
        bus.fillerWord = 12'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.outValid && n < 200) begin
            step();
            n++;
        end
        chk(tag, bus.outValid, 1'b1);
    endtask

    int n;
    int w0;
    int strobes;

    initial begin
        n_checks = 0; n_errors = 0;
        m_run = 0; m_fl = 0; m_k = 0; m_sk = 0;
        m_word = 0; m_data = '0; m_over = 0;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.outReady = 1'b0;
        bus.fillerWord = '0;
        step();
        step();
        reset = 1'b1;

        // Released but not enabled: must stay idle with no strobes
        for (int i = 0; i < 12; i++) step();

        // First strobe exactly TD cycles after leaving IDLE, valid two later
        bus.enable = 1'b1;
        bus.outReady = 1'b1;
        step();
        n = 0;
        while (!bus.bufGetWord && n < 100) begin
            step();
            n++;
        end
        chk("first_strobe_cyc", n, TD);
        step();
        step();
        chk("first_valid",  bus.outValid, 1'b1);
        chk("first_fstart", bus.outFrameStart, 1'b1);

        // Full frame plus a few words at full ready: group and frame wrap
        for (int i = 0; i < (FRAME + 4) * TD; i++) step();

        // Random ready pattern with random filler data
        for (int i = 0; i < 2500; i++) begin
            bus.outReady = ($urandom_range(0, 3) != 0);
            step();
        end

        // Long stall: overrun set, no strobe, pointer advances by exactly one
        bus.outReady = 1'b1;
        wait_valid("stall_wait_valid");
        bus.outReady = 1'b0;
        w0 = bus.cntGrp * WPG + bus.bufRdPointer;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.bufGetWord) strobes++;
        end
        chk("stall_overrun", bus.overrun, 1'b1);
        chk("stall_strobes", strobes, 0);
        bus.outReady = 1'b1;
        step();
        chk("stall_advance", bus.cntGrp * WPG + bus.bufRdPointer, (w0 + 1) % FRAME);

        // Stop request mid-frame: runs to the frame end, then idles
        n = 0;
        while (!(bus.cntGrp == 3 && bus.bufRdPointer == 5) && n < 20000) begin
            bus.outReady = ($urandom_range(0, 4) != 0);
            step();
            n++;
        end
        chk("reach_p5_g3", n < 20000, 1'b1);
        bus.enable = 1'b0;
        n = 0;
        while (bus.busy && n < FRAME * TD * 4) begin
            bus.outReady = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        chk("stop_busy", bus.busy, 1'b0);
        chk("stop_ptr",  bus.bufRdPointer, 0);
        chk("stop_grp",  bus.cntGrp, 0);
        for (int i = 0; i < 10; i++) step();

        // Reset while a word is presented and unaccepted
        bus.enable = 1'b1;
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.outReady = 1'b1;
            wait_valid("pre_rst_valid");
        end
        bus.outReady = 1'b0;
        step();
        reset = 1'b0;
        bus.enable = 1'b0;
        step();
        chk("rst_valid", bus.outValid, 1'b0);
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_word",  bus.outWord, 0);
        reset = 1'b1;
        step();
        bus.enable = 1'b1;

        // Accept only on the tick cycle: overrun must never set
        for (int i = 0; i < 40 * TD; i++) begin
            bus.outReady = m_presenting() && m_tick();
            step();
        end
        chk("tick_hs_overrun", bus.overrun, 1'b0);
        chk("tick_hs_busy",    bus.busy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/m1_frame_sequencer.md
M1_FRAME_SEQUENCER -- requirements
Module: m1_frame_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 16, clock cycles per word slot; legal range 4..255.
REQ-002 Parameter PTR_MAX, default 127, last word pointer in a phrase.
REQ-003 Parameter GRP_MAX, default 31, last group index in a frame.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  run request: 1 = start/continue framing, 0 = stop at next frame boundary.
REQ-007 outReady  input  1  downstream accepts outWord when outValid=1.
REQ-008 fillerWord  input  12  data word returned by the M1 filler, valid one clock after bufGetWord.
REQ-009 bufGetWord  output  1  one-cycle word-request strobe to the filler.
REQ-010 bufRdPointer  output  7  word position within phrase, 0..PTR_MAX.
REQ-011 cntGrp  output  5  group index within frame, 0..GRP_MAX.
REQ-012 outWord  output  12  captured word presented downstream.
REQ-013 outValid  output  1  outWord valid; held until accepted.
REQ-014 outFrameStart  output  1  high with outValid when the presented word is pointer 0, group 0.
REQ-015 overrun  output  1  sticky flag: a slot tick arrived while a word was still unaccepted.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_TICK, STROBE, CAPTURE and PRESENT, fully registered.
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 and wrap in all states except IDLE; tick = (count == TICK_DIV-1); held at 0 in IDLE.
REQ-019 IDLE: enable=1 -> WAIT_TICK; tick counter, pointer and group SHALL be 0; overrun cleared on this transition.
REQ-020 WAIT_TICK: if enable=0 and pointer=0 and group=0 -> IDLE; else on tick -> STROBE; stop requests at other positions are deferred until the frame boundary.
REQ-021 STROBE: bufGetWord=1 for exactly this one cycle; bufRdPointer and cntGrp SHALL be stable from WAIT_TICK through PRESENT; -> CAPTURE.
REQ-022 CAPTURE: fillerWord SHALL be registered into outWord at the end of this cycle; outValid=1 and outFrameStart=(pointer==0 && group==0) from the next cycle; -> PRESENT.
REQ-023 Latency: outValid SHALL rise exactly 2 clocks after the rising edge of bufGetWord.
REQ-024 PRESENT: outValid && outReady SHALL be the handshake; on handshake clear outValid and outFrameStart, advance the pointer, -> WAIT_TICK.
REQ-025 Pointer advance: pointer+1; if pointer==PTR_MAX then pointer=0 and group=group+1; if group==GRP_MAX also, group=0 (frame wrap).
REQ-026 A tick during PRESENT without a handshake in the same cycle SHALL set overrun; the held word is neither dropped nor replaced, and no slot is skipped.
REQ-027 A tick coinciding with a handshake SHALL NOT set overrun.
REQ-028 A tick arriving in STROBE or CAPTURE SHALL be ignored; the next strobe waits for the following tick.
REQ-029 enable is ignored in STROBE, CAPTURE and PRESENT; an in-flight word always completes its handshake.
REQ-030 bufGetWord SHALL never be asserted in two consecutive cycles, and never while outValid=1.

Reset
REQ-031 reset=0 at a rising clk edge SHALL, at any state including mid-handshake, force IDLE and set bufGetWord, bufRdPointer, cntGrp, outWord, outValid, outFrameStart, overrun, busy and the tick counter to 0.
REQ-032 After reset is released, no bufGetWord SHALL occur until enable=1 and one full tick period has elapsed.

Verification
REQ-033 Reset release, enable=1, outReady=1, TICK_DIV=16 -> first bufGetWord on cycle 16 after IDLE exit, ptr=0, grp=0; outValid 2 clocks later with outFrameStart=1 and outWord=fillerWord.
REQ-034 Run 128 words with outReady=1 -> pointer wraps 127->0, cntGrp 0->1; after 4096 words cntGrp wraps 31->0 and outFrameStart reasserts.
REQ-035 Hold outReady=0 for 20 clocks after outValid -> outWord stable, overrun=1, no new bufGetWord; release -> pointer advances by exactly 1.
REQ-036 Drop enable at ptr=5, grp=3 -> sequencing continues to frame end; IDLE entered after ptr=127, grp=31 is accepted; busy=0.
REQ-037 Assert reset=0 in PRESENT with outValid=1 -> next cycle all outputs 0, state IDLE; re-enable restarts at ptr=0, grp=0.
REQ-038 Force tick in the same cycle as the handshake -> overrun stays 0; next strobe occurs on the following tick.
